// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for a shared external
//               combinational ALU. One operation in flight at a time:
//               accept -> execute (one cycle) -> hold response until taken.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  // requester 0
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [1:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  // requester 1
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [1:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  // shared ALU
  output logic [1:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  // response
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_id;   // requester served most recently
  logic   cur_id;    // requester owning the in-flight operation
  logic   grant_id;  // requester chosen this cycle when idle
  logic   accept;    // a request is taken at the next edge

  // Round-robin choice: on contention the requester not served last wins,
  // otherwise whichever requester is asking.
  always_comb begin
    grant_id = 1'b0;
    if (r0_valid && r1_valid) begin
      grant_id = ~last_id;
    end else if (r1_valid) begin
      grant_id = 1'b1;
    end
    accept   = !rst && (state == IDLE) && (r0_valid || r1_valid);
    r0_ready = accept && !grant_id;
    r1_ready = accept &&  grant_id;
  end

  // Transaction sequencing, operand capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_id    <= 1'b1;   // so requester 0 wins the first contention
      cur_id     <= 1'b0;
      alu_opcode <= 2'b00;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_opcode <= grant_id ? r1_op : r0_op;
            alu_a      <= grant_id ? r1_a  : r0_a;
            alu_b      <= grant_id ? r1_b  : r0_b;
            cur_id     <= grant_id;
            last_id    <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_zero  <= (alu_result == '0);
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
